usart_tx_ctrl: RTL

Transmit sequencer for the USART. It pops characters from the TX FIFO and serialises each one onto txd as an asynchronous frame: start bit, 5–9 data bits LSB first, optional parity bit, then 1–2 stop bits. Bit timing comes from an external per-bit baud_tick. It sits between the TX FIFO (configured with SYNC_OUT=0, so dout is combinational and valid whenever the FIFO is non-empty) and the TXD pin logic.

---
 rtl/usart_tx_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/usart_tx_ctrl.sv
// USART transmit sequencer.
// Pops characters from the TX FIFO and serialises each one onto txd as an
// asynchronous frame: start bit, 5..9 data bits LSB first, optional parity,
// then 1..2 stop bits. One bit is emitted per baud_tick.
module usart_tx_ctrl #(
   parameter int DATA_W = 9
) (
   input  logic              cp2,
   input  logic              ireset,
   input  logic              baud_tick,
   input  logic              txen,
   input  logic [2:0]        chsz,
   input  logic [1:0]        upm,
   input  logic              usbs,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   output logic              fifo_re,
   output logic              txd,
   output logic              tx_busy,
   output logic              txc
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
   } state_t;

   state_t            state_q;
   logic              txd_q;
   logic              pend_q;
   logic              txc_q;
   logic              par_q;
   logic [DATA_W-1:0] shreg_q;
   logic [3:0]        cnt_q;
   // Config shadows, packed as {chsz[2:0], upm[1:0], usbs}.
   // cfgp_q is captured with the popped character; cfga_q belongs to the
   // frame on the wire, so a prefetch during the stop bits cannot disturb
   // the stop-bit count of the frame still finishing.
   logic [5:0]        cfgp_q;
   logic [5:0]        cfga_q;
   logic              pop;
   logic [3:0]        nbits;

   // Data bits for the active frame; reserved encodings fall back to 8.
   always_comb begin
      case (cfga_q[5:3])
         3'b000:  nbits = 4'd5;
         3'b001:  nbits = 4'd6;
         3'b010:  nbits = 4'd7;
         3'b111:  nbits = 4'd9;
         default: nbits = 4'd8;
      endcase
   end

   // Pop only when nothing is waiting and the line is idle or in stop bits.
   assign pop = !ireset & txen & !fifo_empty & !pend_q &
                ((state_q == S_IDLE) | (state_q == S_STOP1) | (state_q == S_STOP2));

   assign fifo_re = pop;
   assign txd     = txd_q;
   assign txc     = txc_q;
   assign tx_busy = (state_q != S_IDLE) | pend_q;

   // Frame sequencer: FIFO load, bit shifting, parity and stop-bit handling.
   always_ff @(posedge cp2 or posedge ireset) begin
      if (ireset) begin
         state_q <= S_IDLE;
         txd_q   <= 1'b1;
         pend_q  <= 1'b0;
         txc_q   <= 1'b0;
         par_q   <= 1'b0;
         shreg_q <= '0;
         cnt_q   <= 4'd0;
         cfgp_q  <= 6'd0;
         cfga_q  <= 6'd0;
      end else begin
         txc_q <= 1'b0;
         if (pop) begin
            shreg_q <= fifo_dout;
            cfgp_q  <= {chsz, upm, usbs};
            pend_q  <= 1'b1;
         end
         if (baud_tick) begin
            case (state_q)
               S_IDLE: begin
                  if (pend_q) begin
                     state_q <= S_START;
                     txd_q   <= 1'b0;
                     pend_q  <= 1'b0;
                     cnt_q   <= 4'd0;
                     par_q   <= cfgp_q[1];
                     cfga_q  <= cfgp_q;
                  end
               end
               S_START: begin
                  state_q <= S_DATA;
                  txd_q   <= shreg_q[0];
                  par_q   <= par_q ^ shreg_q[0];
                  shreg_q <= shreg_q >> 1;
                  cnt_q   <= 4'd1;
               end
               S_DATA: begin
                  if (cnt_q == nbits) begin
                     if (cfga_q[2]) begin
                        state_q <= S_PARITY;
                        txd_q   <= par_q;
                     end else begin
                        state_q <= S_STOP1;
                        txd_q   <= 1'b1;
                     end
                  end else begin
                     txd_q   <= shreg_q[0];
                     par_q   <= par_q ^ shreg_q[0];
                     shreg_q <= shreg_q >> 1;
                     cnt_q   <= cnt_q + 4'd1;
                  end
               end
               S_PARITY: begin
                  state_q <= S_STOP1;
                  txd_q   <= 1'b1;
               end
               S_STOP1, S_STOP2: begin
                  if ((state_q == S_STOP1) && cfga_q[0]) begin
                     state_q <= S_STOP2;
                  end else if (pend_q) begin
                     // Back-to-back: next start bit follows the stop bit directly.
                     state_q <= S_START;
                     txd_q   <= 1'b0;
                     pend_q  <= 1'b0;
                     cnt_q   <= 4'd0;
                     par_q   <= cfgp_q[1];
                     cfga_q  <= cfgp_q;
                  end else begin
                     state_q <= S_IDLE;
                     txd_q   <= 1'b1;
                     txc_q   <= 1'b1;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  txd_q   <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
